// File: rtl/spi_rule_injector_if.sv
// SPI line and control/status bundle for the rule-based SD-over-SPI fault injector.
interface spi_rule_injector_if #(
  parameter int unsigned NUM_RULES = 4,
  parameter int unsigned CNT_W     = 8
);
  logic                   MOSI_IN;
  logic                   MOSI_OUT;
  logic                   MISO_IN;
  logic                   MISO_OUT;
  logic [5:0]             io_MOSICommand;
  logic                   io_MOSIReadSuccess;
  logic                   io_MOSIWaitingWriteToken;
  logic                   io_Armed;
  logic [NUM_RULES-1:0]   io_RuleEnable;
  logic [6*NUM_RULES-1:0] io_RuleCmd;
  logic [2*NUM_RULES-1:0] io_RuleMode;
  logic [CNT_W*NUM_RULES-1:0] io_RuleSkip;
  logic [15:0]            io_InjectCount;
  logic                   io_Busy;
  logic [7:0]             io___dbg_state;

  modport master (
    output MOSI_IN, MISO_IN, io_MOSICommand, io_MOSIReadSuccess,
           io_MOSIWaitingWriteToken, io_Armed, io_RuleEnable, io_RuleCmd,
           io_RuleMode, io_RuleSkip,
    input  MOSI_OUT, MISO_OUT, io_InjectCount, io_Busy, io___dbg_state
  );

  modport slave (
    input  MOSI_IN, MISO_IN, io_MOSICommand, io_MOSIReadSuccess,
           io_MOSIWaitingWriteToken, io_Armed, io_RuleEnable, io_RuleCmd,
           io_RuleMode, io_RuleSkip,
    output MOSI_OUT, MISO_OUT, io_InjectCount, io_Busy, io___dbg_state
  );
endinterface

// File: rtl/spi_rule_injector.sv
// Inline SPI fault injector: matches a command against programmable rules, skips
// N write-token blocks, then shifts an error token on MISO or a stop token on MOSI.
module spi_rule_injector #(
  parameter int unsigned       NUM_RULES  = 4,
  parameter int unsigned       TOK_W      = 8,
  parameter int unsigned       CNT_W      = 8,
  parameter logic [TOK_W-1:0]  ERR_TOKEN  = TOK_W'(8'h0F),
  parameter logic [TOK_W-1:0]  STOP_TOKEN = TOK_W'(8'hFD)
) (
  input logic                  CLK,
  input logic                  async_reset_n,
  spi_rule_injector_if.slave   bus
);
  localparam int unsigned BIT_W = $clog2(TOK_W + 1);

  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_MATCHED    = 3'd1,
    ST_SHIFT_MISO = 3'd2,
    ST_SHIFT_MOSI = 3'd3,
    ST_HOLD       = 3'd4
  } state_e;

  state_e             state_q, state_d;
  logic               rs_hist_q, rs_hist_d;
  logic               wt_hist_q, wt_hist_d;
  logic [1:0]         mode_q, mode_d;
  logic [CNT_W-1:0]   skip_q, skip_d;
  logic [CNT_W-1:0]   blk_cnt_q, blk_cnt_d;
  logic [BIT_W-1:0]   bit_cnt_q, bit_cnt_d;
  logic               mosi_sel_q, mosi_sel_d;
  logic               mosi_dat_q, mosi_dat_d;
  logic               miso_sel_q, miso_sel_d;
  logic               miso_dat_q, miso_dat_d;
  logic [15:0]        inj_cnt_q, inj_cnt_d;
  logic               busy_q, busy_d;

  logic               rs_rise, wt_rise, inj_inc;
  logic               hit;
  logic [1:0]         hit_mode;
  logic [CNT_W-1:0]   hit_skip;
  logic [TOK_W-1:0]   err_sh, stop_sh;
  logic               last_bit;

  assign rs_rise  = bus.io_MOSIReadSuccess & ~rs_hist_q;
  assign wt_rise  = bus.io_MOSIWaitingWriteToken & ~wt_hist_q;
  assign err_sh   = ERR_TOKEN << bit_cnt_q;
  assign stop_sh  = STOP_TOKEN << bit_cnt_q;
  assign last_bit = (bit_cnt_q == BIT_W'(TOK_W - 1));

  // Lowest-index enabled rule wins: scan downwards so the last hit is the lowest.
  always_comb begin
    hit      = 1'b0;
    hit_mode = '0;
    hit_skip = '0;
    for (int i = int'(NUM_RULES) - 1; i >= 0; i--) begin
      if (bus.io_RuleEnable[i] && (bus.io_RuleCmd[i*6 +: 6] == bus.io_MOSICommand)) begin
        hit      = 1'b1;
        hit_mode = bus.io_RuleMode[i*2 +: 2];
        hit_skip = bus.io_RuleSkip[i*CNT_W +: CNT_W];
      end
    end
  end

  always_comb begin
    state_d    = state_q;
    rs_hist_d  = bus.io_MOSIReadSuccess;
    wt_hist_d  = bus.io_MOSIWaitingWriteToken;
    mode_d     = mode_q;
    skip_d     = skip_q;
    blk_cnt_d  = blk_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    mosi_sel_d = mosi_sel_q;
    mosi_dat_d = mosi_dat_q;
    miso_sel_d = miso_sel_q;
    miso_dat_d = miso_dat_q;
    inj_inc    = 1'b0;

    case (state_q)
      ST_IDLE: begin
        mosi_sel_d = 1'b0;
        miso_sel_d = 1'b0;
        mosi_dat_d = 1'b1;
        miso_dat_d = 1'b1;
        bit_cnt_d  = '0;
        if (rs_rise && bus.io_Armed && hit) begin
          mode_d    = hit_mode;
          skip_d    = hit_skip;
          blk_cnt_d = '0;
          state_d   = ST_MATCHED;
        end
      end
      ST_MATCHED: begin
        // Transaction end beats a token edge seen on the same clock.
        if (!bus.io_MOSIReadSuccess) begin
          state_d = ST_IDLE;
        end else if (wt_rise) begin
          if (blk_cnt_q < skip_q) begin
            if (blk_cnt_q != {CNT_W{1'b1}}) blk_cnt_d = blk_cnt_q + CNT_W'(1);
          end else begin
            case (mode_q)
              2'd0: begin
                miso_sel_d = 1'b1;
                miso_dat_d = ERR_TOKEN[TOK_W-1];
                bit_cnt_d  = BIT_W'(1);
                state_d    = ST_SHIFT_MISO;
              end
              2'd1: begin
                mosi_sel_d = 1'b1;
                mosi_dat_d = STOP_TOKEN[TOK_W-1];
                bit_cnt_d  = BIT_W'(1);
                state_d    = ST_SHIFT_MOSI;
              end
              default: begin
                inj_inc = 1'b1;
                state_d = ST_IDLE;
              end
            endcase
          end
        end
      end
      ST_SHIFT_MISO: begin
        miso_dat_d = err_sh[TOK_W-1];
        bit_cnt_d  = bit_cnt_q + BIT_W'(1);
        if (last_bit) begin
          inj_inc = 1'b1;
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT_MOSI: begin
        mosi_dat_d = stop_sh[TOK_W-1];
        bit_cnt_d  = bit_cnt_q + BIT_W'(1);
        if (last_bit) begin
          inj_inc = 1'b1;
          state_d = ST_HOLD;
        end
      end
      ST_HOLD: begin
        mosi_sel_d = 1'b1;
        mosi_dat_d = 1'b1;
        if (!bus.io_MOSIReadSuccess) begin
          mosi_sel_d = 1'b0;
          state_d    = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    inj_cnt_d = inj_cnt_q;
    if (inj_inc && (inj_cnt_q != 16'hFFFF)) inj_cnt_d = inj_cnt_q + 16'd1;
    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(negedge CLK or negedge async_reset_n) begin
    if (!async_reset_n) begin
      state_q    <= ST_IDLE;
      rs_hist_q  <= 1'b0;
      wt_hist_q  <= 1'b0;
      mode_q     <= '0;
      skip_q     <= '0;
      blk_cnt_q  <= '0;
      bit_cnt_q  <= '0;
      mosi_sel_q <= 1'b0;
      mosi_dat_q <= 1'b1;
      miso_sel_q <= 1'b0;
      miso_dat_q <= 1'b1;
      inj_cnt_q  <= '0;
      busy_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      rs_hist_q  <= rs_hist_d;
      wt_hist_q  <= wt_hist_d;
      mode_q     <= mode_d;
      skip_q     <= skip_d;
      blk_cnt_q  <= blk_cnt_d;
      bit_cnt_q  <= bit_cnt_d;
      mosi_sel_q <= mosi_sel_d;
      mosi_dat_q <= mosi_dat_d;
      miso_sel_q <= miso_sel_d;
      miso_dat_q <= miso_dat_d;
      inj_cnt_q  <= inj_cnt_d;
      busy_q     <= busy_d;
    end
  end

  assign bus.MOSI_OUT       = mosi_sel_q ? mosi_dat_q : bus.MOSI_IN;
  assign bus.MISO_OUT       = miso_sel_q ? miso_dat_q : bus.MISO_IN;
  assign bus.io_InjectCount = inj_cnt_q;
  assign bus.io_Busy        = busy_q;
  assign bus.io___dbg_state = 8'(state_q);
endmodule

// File: tb/tb_spi_rule_injector.sv
// Directed bench for spi_rule_injector: token shapes, skip, priority, abort, reset and arming.
module tb_spi_rule_injector;
  localparam int unsigned NR = 4;
  localparam int unsigned CW = 8;

  logic CLK;
  logic async_reset_n;
  int   n_cmp;
  int   n_err;
  logic [7:0] err_tok;
  logic [7:0] stop_tok;

  spi_rule_injector_if #(.NUM_RULES(NR), .CNT_W(CW)) bus ();

  spi_rule_injector #(
    .NUM_RULES(NR), .TOK_W(8), .CNT_W(CW),
    .ERR_TOKEN(8'h0F), .STOP_TOKEN(8'hFD)
  ) dut (
    .CLK(CLK),
    .async_reset_n(async_reset_n),
    .bus(bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Advance exactly one falling edge, then settle in the high phase.
  task automatic fall();
    @(negedge CLK);
    @(posedge CLK);
    #1;
  endtask

  task automatic set_rule(input int i, input logic en, input logic [5:0] cmd,
                          input logic [1:0] mode, input logic [7:0] skip);
    bus.io_RuleEnable[i]      = en;
    bus.io_RuleCmd[i*6 +: 6]  = cmd;
    bus.io_RuleMode[i*2 +: 2] = mode;
    bus.io_RuleSkip[i*8 +: 8] = skip;
  endtask

  initial begin
    n_cmp = 0;
    n_err = 0;
    err_tok  = 8'h0F;
    stop_tok = 8'hFD;
    async_reset_n = 1'b0;
    bus.MOSI_IN = 1'b0;
    bus.MISO_IN = 1'b0;
    bus.io_MOSICommand = 6'd0;
    bus.io_MOSIReadSuccess = 1'b0;
    bus.io_MOSIWaitingWriteToken = 1'b0;
    bus.io_Armed = 1'b0;
    bus.io_RuleEnable = '0;
    bus.io_RuleCmd = '0;
    bus.io_RuleMode = '0;
    bus.io_RuleSkip = '0;
    fall();
    fall();
    check("rst_mosi", 32'(bus.MOSI_OUT), 32'd0);
    check("rst_miso", 32'(bus.MISO_OUT), 32'd0);
    check("rst_state", 32'(bus.io___dbg_state), 32'd0);
    check("rst_count", 32'(bus.io_InjectCount), 32'd0);
    check("rst_busy", 32'(bus.io_Busy), 32'd0);
    async_reset_n = 1'b1;
    fall();

    // Rule0 CMD24 MISO error token, no skip
    set_rule(0, 1'b1, 6'd24, 2'd0, 8'd0);
    bus.io_Armed = 1'b1;
    bus.io_MOSICommand = 6'd24;
    bus.io_MOSIReadSuccess = 1'b1;
    fall();
    check("t1_matched", 32'(bus.io___dbg_state), 32'd1);
    check("t1_busy", 32'(bus.io_Busy), 32'd1);
    bus.io_MOSIWaitingWriteToken = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus.MISO_IN = ~err_tok[7-k];
      fall();
      check($sformatf("t1_bit%0d", k), 32'(bus.MISO_OUT), 32'(err_tok[7-k]));
    end
    check("t1_idle", 32'(bus.io___dbg_state), 32'd0);
    check("t1_count", 32'(bus.io_InjectCount), 32'd1);
    bus.MISO_IN = 1'b0;
    fall();
    check("t1_release", 32'(bus.MISO_OUT), 32'd0);
    bus.MISO_IN = 1'b1;
    #1;
    check("t1_follow", 32'(bus.MISO_OUT), 32'd1);
    bus.io_MOSIReadSuccess = 1'b0;
    bus.io_MOSIWaitingWriteToken = 1'b0;
    fall();

    // Rule1 CMD25 MOSI stop token after two skipped blocks
    set_rule(0, 1'b0, 6'd24, 2'd0, 8'd0);
    set_rule(1, 1'b1, 6'd25, 2'd1, 8'd2);
    bus.io_MOSICommand = 6'd25;
    bus.io_MOSIReadSuccess = 1'b1;
    bus.MOSI_IN = 1'b0;
    fall();
    check("t2_matched", 32'(bus.io___dbg_state), 32'd1);
    for (int r = 0; r < 2; r++) begin
      bus.io_MOSIWaitingWriteToken = 1'b1;
      fall();
      check($sformatf("t2_skip%0d_mosi", r), 32'(bus.MOSI_OUT), 32'd0);
      check($sformatf("t2_skip%0d_state", r), 32'(bus.io___dbg_state), 32'd1);
      bus.io_MOSIWaitingWriteToken = 1'b0;
      fall();
    end
    bus.io_MOSIWaitingWriteToken = 1'b1;
    for (int k = 0; k < 8; k++) begin
      bus.MOSI_IN = ~stop_tok[7-k];
      fall();
      check($sformatf("t2_bit%0d", k), 32'(bus.MOSI_OUT), 32'(stop_tok[7-k]));
    end
    check("t2_hold", 32'(bus.io___dbg_state), 32'd4);
    check("t2_count", 32'(bus.io_InjectCount), 32'd2);
    bus.MOSI_IN = 1'b0;
    fall();
    check("t2_hold_mosi_a", 32'(bus.MOSI_OUT), 32'd1);
    fall();
    check("t2_hold_mosi_b", 32'(bus.MOSI_OUT), 32'd1);
    check("t2_hold_busy", 32'(bus.io_Busy), 32'd1);
    bus.io_MOSIReadSuccess = 1'b0;
    bus.io_MOSIWaitingWriteToken = 1'b0;
    fall();
    check("t2_idle", 32'(bus.io___dbg_state), 32'd0);
    check("t2_release", 32'(bus.MOSI_OUT), 32'd0);

    // Rules 0 and 2 both match CMD25: rule0 (MISO) must win over rule2 (MOSI)
    set_rule(0, 1'b1, 6'd25, 2'd0, 8'd0);
    set_rule(1, 1'b0, 6'd25, 2'd1, 8'd2);
    set_rule(2, 1'b1, 6'd25, 2'd1, 8'd0);
    bus.io_MOSIReadSuccess = 1'b1;
    fall();
    bus.io_MOSIWaitingWriteToken = 1'b1;
    bus.MISO_IN = 1'b1;
    bus.MOSI_IN = 1'b0;
    fall();
    check("t3_state", 32'(bus.io___dbg_state), 32'd2);
    check("t3_miso", 32'(bus.MISO_OUT), 32'd0);
    check("t3_mosi", 32'(bus.MOSI_OUT), 32'd0);
    for (int k = 1; k < 8; k++) fall();
    check("t3_count", 32'(bus.io_InjectCount), 32'd3);
    bus.io_MOSIReadSuccess = 1'b0;
    bus.io_MOSIWaitingWriteToken = 1'b0;
    fall();

    // Skip 5, transaction ends with a token edge on the same clock: abort
    set_rule(0, 1'b1, 6'd25, 2'd0, 8'd5);
    set_rule(2, 1'b0, 6'd25, 2'd1, 8'd0);
    bus.io_MOSIReadSuccess = 1'b1;
    fall();
    for (int r = 0; r < 2; r++) begin
      bus.io_MOSIWaitingWriteToken = 1'b1;
      fall();
      bus.io_MOSIWaitingWriteToken = 1'b0;
      fall();
    end
    check("t4_still_matched", 32'(bus.io___dbg_state), 32'd1);
    bus.io_MOSIReadSuccess = 1'b0;
    bus.io_MOSIWaitingWriteToken = 1'b1;
    bus.MISO_IN = 1'b0;
    fall();
    check("t4_idle", 32'(bus.io___dbg_state), 32'd0);
    check("t4_count", 32'(bus.io_InjectCount), 32'd3);
    check("t4_miso", 32'(bus.MISO_OUT), 32'd0);
    check("t4_busy", 32'(bus.io_Busy), 32'd0);
    bus.io_MOSIWaitingWriteToken = 1'b0;
    fall();

    // Async reset in the middle of a MISO shift
    set_rule(0, 1'b1, 6'd24, 2'd0, 8'd0);
    bus.io_MOSICommand = 6'd24;
    bus.io_MOSIReadSuccess = 1'b1;
    fall();
    bus.io_MOSIWaitingWriteToken = 1'b1;
    bus.MISO_IN = 1'b1;
    for (int k = 0; k < 4; k++) fall();
    check("t5_pre_miso", 32'(bus.MISO_OUT), 32'd0);
    check("t5_pre_state", 32'(bus.io___dbg_state), 32'd2);
    async_reset_n = 1'b0;
    #1;
    check("t5_miso", 32'(bus.MISO_OUT), 32'd1);
    check("t5_state", 32'(bus.io___dbg_state), 32'd0);
    check("t5_count", 32'(bus.io_InjectCount), 32'd0);
    check("t5_busy", 32'(bus.io_Busy), 32'd0);
    bus.io_MOSIReadSuccess = 1'b0;
    bus.io_MOSIWaitingWriteToken = 1'b0;
    fall();
    async_reset_n = 1'b1;
    fall();

    // Disarmed at match time, then Armed dropped mid-shift
    bus.io_Armed = 1'b0;
    bus.io_MOSIReadSuccess = 1'b1;
    fall();
    check("t6_disarmed_busy", 32'(bus.io_Busy), 32'd0);
    check("t6_disarmed_state", 32'(bus.io___dbg_state), 32'd0);
    bus.io_Armed = 1'b1;
    fall();
    check("t6_no_new_rise", 32'(bus.io___dbg_state), 32'd0);
    bus.io_MOSIReadSuccess = 1'b0;
    fall();
    bus.io_MOSIReadSuccess = 1'b1;
    fall();
    check("t6_matched", 32'(bus.io___dbg_state), 32'd1);
    bus.io_MOSIWaitingWriteToken = 1'b1;
    for (int k = 0; k < 8; k++) begin
      if (k == 2) bus.io_Armed = 1'b0;
      bus.MISO_IN = ~err_tok[7-k];
      fall();
      check($sformatf("t6_bit%0d", k), 32'(bus.MISO_OUT), 32'(err_tok[7-k]));
    end
    check("t6_count", 32'(bus.io_InjectCount), 32'd1);
    check("t6_idle", 32'(bus.io___dbg_state), 32'd0);
    bus.io_MOSIReadSuccess = 1'b0;
    bus.io_MOSIWaitingWriteToken = 1'b0;
    fall();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
